// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests one word at oPC, issues it to the datapath, then selects the next PC.
// Optional fetch watchdog is built when FETCH_TIMEOUT_EN is defined; the default build has no watchdog.
module instr_fetch_unit #(
  parameter logic [31:0] INITIAL_PC     = 32'h0040_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  // instruction memory
  output logic        oIMemReq,
  output logic [31:0] oIMemAddr,
  input  logic        iIMemAck,
  input  logic [31:0] iIMemData,
  // issue to control unit / datapath
  output logic [31:0] oInstr,
  output logic [31:0] oPC,
  output logic        oInstrValid,
  input  logic        iInstrReady,
  // next-PC selection
  input  logic [1:0]  iOrigPC,
  input  logic        iBranchTaken,
  input  logic [31:0] iBranchTarget,
  input  logic [31:0] iJalTarget,
  input  logic [31:0] iJalrTarget,
  // faults and statistics
  output logic        oMisaligned,
  output logic [31:0] oBadAddr,
  output logic        oTimeout,
  output logic [31:0] oInstrCount
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } pc_src_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] bad_addr_q, bad_addr_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        next_pc_bad;

`ifdef FETCH_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
  logic        timeout_q, timeout_d;
`endif

  // JALR bit 0 is discarded by the architecture, and the watchdog limit is unused in the default build.
  logic unused_inputs;
  assign unused_inputs = ^{TIMEOUT_CYCLES, iJalrTarget[0]};

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src_e'(iOrigPC))
      PC_SEQ:    next_pc = pc_plus4;
      PC_BRANCH: next_pc = iBranchTaken ? iBranchTarget : pc_plus4;
      PC_JAL:    next_pc = iJalTarget;
      PC_JALR:   next_pc = {iJalrTarget[31:1], 1'b0};
      default:   next_pc = pc_plus4;
    endcase
  end

  assign next_pc_bad = (next_pc[1:0] != 2'b00);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= START;
    else      state_q <= state_d;
  end

  // NOTE: reset lives in the sensitivity list, so the architectural registers take their reset values without a clock.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pc_q         <= INITIAL_PC;
      instr_q      <= NOP_INSTR;
      count_q      <= '0;
      misaligned_q <= 1'b0;
      bad_addr_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
      timer_q      <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
      bad_addr_q   <= bad_addr_d;
`ifdef FETCH_TIMEOUT_EN
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the case infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    count_d      = count_q;
    misaligned_d = misaligned_q;
    bad_addr_d   = bad_addr_q;
`ifdef FETCH_TIMEOUT_EN
    timer_d      = timer_q;
    timeout_d    = timeout_q;
`endif

    unique case (state_q)
      START: begin
        state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
        timer_d = '0;
`endif
      end

      FETCH: begin
        if (iIMemAck) begin
          instr_d = iIMemData;
          state_d = ISSUE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if ((timer_q + 32'd1) >= TIMEOUT_CYCLES) begin
          timeout_d = 1'b1;
          state_d   = HALT;
        end else begin
          timer_d = timer_q + 32'd1;
        end
`endif
      end

      ISSUE: begin
        if (iInstrReady) begin
          count_d = count_q + 32'd1;
          if (next_pc_bad) begin
            // The faulting instruction's PC stays visible; the bad target is reported separately.
            misaligned_d = 1'b1;
            bad_addr_d   = next_pc;
            state_d      = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
            timer_d = '0;
`endif
          end
        end
      end

      HALT: state_d = HALT;

      default: state_d = START;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    oIMemReq    = 1'b0;
    oInstrValid = 1'b0;
    unique case (state_q)
      FETCH:   oIMemReq    = 1'b1;
      ISSUE:   oInstrValid = 1'b1;
      default: ;
    endcase
  end

  assign oIMemAddr   = pc_q;
  assign oPC         = pc_q;
  assign oInstr      = instr_q;
  assign oInstrCount = count_q;
  assign oMisaligned = misaligned_q;
  assign oBadAddr    = bad_addr_q;

`ifdef FETCH_TIMEOUT_EN
  assign oTimeout = timeout_q;
`else
  assign oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized fetch/issue traffic
// compared against a transaction-level PC/count model.
module tb_instr_fetch_unit;

  localparam logic [31:0] INIT_PC = 32'h0040_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        ack;
  logic [31:0] data;
  logic        ready;
  logic [1:0]  orig;
  logic        taken;
  logic [31:0] btgt, jtgt, jrtgt;

  logic        req, valid, mis, tmo;
  logic [31:0] addr, instr, pc, bad, cnt;

  // second instance: always-acking memory, always-ready datapath, starting at the top of the address space
  logic        w_req, w_valid, w_mis, w_tmo;
  logic [31:0] w_addr, w_instr, w_pc, w_bad, w_cnt;
  logic        one;
  logic [1:0]  zero2;
  logic [31:0] zero32;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] m_pc;
  logic [31:0] m_count;

  instr_fetch_unit #(.INITIAL_PC(INIT_PC), .TIMEOUT_CYCLES(16)) u_dut (
    .iCLK(clk), .iRST(rst),
    .oIMemReq(req), .oIMemAddr(addr), .iIMemAck(ack), .iIMemData(data),
    .oInstr(instr), .oPC(pc), .oInstrValid(valid), .iInstrReady(ready),
    .iOrigPC(orig), .iBranchTaken(taken),
    .iBranchTarget(btgt), .iJalTarget(jtgt), .iJalrTarget(jrtgt),
    .oMisaligned(mis), .oBadAddr(bad), .oTimeout(tmo), .oInstrCount(cnt)
  );

  instr_fetch_unit #(.INITIAL_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) u_dut_wrap (
    .iCLK(clk), .iRST(rst),
    .oIMemReq(w_req), .oIMemAddr(w_addr), .iIMemAck(one), .iIMemData(NOP),
    .oInstr(w_instr), .oPC(w_pc), .oInstrValid(w_valid), .iInstrReady(one),
    .iOrigPC(zero2), .iBranchTaken(one),
    .iBranchTarget(zero32), .iJalTarget(zero32), .iJalrTarget(zero32),
    .oMisaligned(w_mis), .oBadAddr(w_bad), .oTimeout(w_tmo), .oInstrCount(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [1:0] src,
                                              input logic tk, input logic [31:0] b,
                                              input logic [31:0] j, input logic [31:0] jr);
    case (src)
      2'b00:   return cur + 32'd4;
      2'b01:   return tk ? b : cur + 32'd4;
      2'b10:   return j;
      default: return jr & 32'hFFFF_FFFE;
    endcase
  endfunction

  // Asynchronous reset with junk ack during reset and START; leaves the DUT one cycle into FETCH.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ack = 1'b1; data = 32'hDEAD_BEEF; ready = 1'b1;
    #1;
    check("rst_pc",    pc,    INIT_PC);
    check("rst_addr",  addr,  INIT_PC);
    check("rst_instr", instr, NOP);
    check("rst_valid", valid, 0);
    check("rst_req",   req,   0);
    check("rst_mis",   mis,   0);
    check("rst_bad",   bad,   0);
    check("rst_tmo",   tmo,   0);
    check("rst_cnt",   cnt,   0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    ack = 1'b0; ready = 1'b0;
    check("start_ack_ignored", instr, NOP);
    check("fetch_req", req, 1);
    m_pc = INIT_PC;
    m_count = 0;
  endtask

  // One fetch/issue/retire transaction; entered and left at posedge+1 with the DUT in FETCH (or HALT).
  task automatic run_instr(input int ack_dly, input int rdy_dly, input logic [31:0] d,
                           input logic [1:0] o, input logic tk, input logic [31:0] bt,
                           input logic [31:0] jt, input logic [31:0] jrt, output bit halted);
    logic [31:0] nxt;
    check("f_req",   req,   1);
    check("f_addr",  addr,  m_pc);
    check("f_valid", valid, 0);
    for (int i = 0; i < ack_dly; i++) begin
      ack = 1'b0; ready = 1'($urandom); data = $urandom;
      @(posedge clk); #1;
      check("f_wait_req", req, 1);
      check("f_wait_valid", valid, 0);
    end
    ack = 1'b1; data = d; ready = 1'($urandom);
    @(posedge clk); #1;
    ack = 1'b0;
    check("i_valid", valid, 1);
    check("i_req",   req,   0);
    check("i_instr", instr, d);
    check("i_pc",    pc,    m_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      ready = 1'b0; ack = 1'($urandom); data = $urandom; orig = 2'($urandom);
      @(posedge clk); #1;
      check("hold_instr", instr, d);
      check("hold_pc",    pc,    m_pc);
      check("hold_valid", valid, 1);
    end
    ready = 1'b1; ack = 1'b0; orig = o; taken = tk; btgt = bt; jtgt = jt; jrtgt = jrt;
    @(posedge clk); #1;
    ready = 1'b0;
    nxt = ref_next_pc(m_pc, o, tk, bt, jt, jrt);
    m_count = m_count + 1;
    check("retire_cnt", cnt, m_count);
    if (nxt[1:0] != 2'b00) begin
      halted = 1'b1;
      check("halt_mis",   mis,   1);
      check("halt_bad",   bad,   nxt);
      check("halt_pc",    pc,    m_pc);
      check("halt_valid", valid, 0);
      check("halt_req",   req,   0);
      for (int i = 0; i < 3; i++) begin
        ack = 1'b1; ready = 1'($urandom); data = $urandom;
        @(posedge clk); #1;
        check("halt_stay_req",   req,   0);
        check("halt_stay_valid", valid, 0);
        check("halt_stay_cnt",   cnt,   m_count);
      end
      ack = 1'b0;
    end else begin
      halted = 1'b0;
      m_pc = nxt;
      check("no_fault", mis, 0);
    end
  endtask

  initial begin
    bit          h;
    int          t0;
    logic [31:0] t;
    logic [1:0]  o;

    one = 1'b1; zero2 = 2'b00; zero32 = 32'h0;
    rst = 1'b0; ack = 1'b0; data = '0; ready = 1'b0;
    orig = 2'b00; taken = 1'b0; btgt = '0; jtgt = '0; jrtgt = '0;

    // wrap instance: PC+4 from 0xFFFFFFFC wraps to 0
    do_reset();
    check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    repeat (2) begin @(posedge clk); #1; end
    check("wrap_next_addr", w_addr, 32'h0000_0000);
    check("wrap_req",       w_req,  1);
    check("wrap_cnt",       w_cnt,  1);

    // back-to-back sequential fetch at 2 cycles per instruction
    do_reset();
    t0 = cyc;
    repeat (3) run_instr(0, 0, NOP, 2'b00, 1'b0, '0, '0, '0, h);
    check("cpi_3_instr", cyc - t0, 6);
    check("cnt_after_3", cnt, 3);
    run_instr(0, 0, NOP, 2'b00, 1'b0, '0, '0, '0, h);
    // stalled ISSUE at 0x00400010 then taken branch
    check("pc_0x10", pc, 32'h0040_0010);
    run_instr(1, 5, 32'h1234_5678, 2'b01, 1'b1, 32'h0040_0100, '0, '0, h);
    check("branch_addr", addr, 32'h0040_0100);
    run_instr(0, 0, NOP, 2'b11, 1'b0, '0, '0, 32'h0040_0201, h);
    check("jalr_addr", addr, 32'h0040_0200);
    run_instr(0, 0, NOP, 2'b10, 1'b0, '0, 32'h0040_0102, '0, h);
    check("jal_bad_addr", bad, 32'h0040_0102);

    // randomized traffic
    do_reset();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      t = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 24) == 0) t[1] = 1'b1;
      if ($urandom_range(0, 24) == 0) t[0] = 1'b1;
      o = 2'($urandom);
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom, o, 1'($urandom),
                t, t ^ {30'h0, 2'($urandom_range(0, 1))}, t | {31'h0, 1'($urandom)}, h);
      if (h) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
